// File: rtl/alu_rr_scheduler.sv
// alu_rr_scheduler: shares one combinational ALU between NREQ requesters.
// The arbiter is round-robin. The chosen request's operands are registered
// onto the ALU inputs. The result and flags are captured into a response
// register, which is held until the consumer accepts it.
// Optional feature macro: ALU_SCHED_DIV_MULTICYCLE_EN. When it is defined,
// DIV (opcode 6) operands are held DIV_CYCLES cycles before capture.
module alu_rr_scheduler #(
    parameter int WIDTH      = 8,
    parameter int NREQ       = 2,
    parameter int DIV_CYCLES = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NREQ-1:0]                   req_valid,
    output logic [NREQ-1:0]                   req_ready,
    input  logic [4*NREQ-1:0]                 req_opcode,
    input  logic [WIDTH*NREQ-1:0]             req_input1,
    input  logic [WIDTH*NREQ-1:0]             req_input2,
    input  logic [5*NREQ-1:0]                 req_shift,
    output logic [3:0]                        alu_opcode,
    output logic [WIDTH-1:0]                  alu_input1,
    output logic [WIDTH-1:0]                  alu_input2,
    output logic [4:0]                        alu_shift,
    input  logic [WIDTH-1:0]                  alu_result,
    input  logic                              alu_carry,
    input  logic                              alu_zero,
    input  logic                              alu_overflow,
    input  logic                              alu_sign,
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] rsp_id,
    output logic [WIDTH-1:0]                  rsp_result,
    output logic [3:0]                        rsp_flags,
    output logic                              rsp_err
);

    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    // Counter only needs to reach DIV_CYCLES-1
    localparam int CW  = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t           state_r;
    logic [IDW-1:0]   ptr_r;
    logic [CW-1:0]    cnt_r;

    logic             found_s;
    logic [IDW-1:0]   win_s;
    logic [IDW-1:0]   nxt_ptr_s;
    logic [3:0]       sel_op_s;
    logic [WIDTH-1:0] sel_in1_s;
    logic [WIDTH-1:0] sel_in2_s;
    logic [4:0]       sel_sh_s;
    logic [CW-1:0]    div_hold_s;

    // Round-robin search: first valid requester at or above the pointer, with wrap
    always_comb begin
        found_s = 1'b0;
        win_s   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found_s && req_valid[(int'(ptr_r) + k) % NREQ]) begin
                found_s = 1'b1;
                win_s   = IDW'((int'(ptr_r) + k) % NREQ);
            end else begin
                win_s   = win_s;
            end
        end
    end

    // Payload of the winning requester and the pointer value after its accept
    always_comb begin
        sel_op_s  = req_opcode[int'(win_s)*4 +: 4];
        sel_in1_s = req_input1[int'(win_s)*WIDTH +: WIDTH];
        sel_in2_s = req_input2[int'(win_s)*WIDTH +: WIDTH];
        sel_sh_s  = req_shift[int'(win_s)*5 +: 5];
        if (int'(win_s) == NREQ - 1) begin
            nxt_ptr_s = '0;
        end else begin
            nxt_ptr_s = win_s + IDW'(1'b1);
        end
    end

    // Hold count loaded on accept; only DIV is stretched, and only when enabled
    always_comb begin
`ifdef ALU_SCHED_DIV_MULTICYCLE_EN
        if (sel_op_s == 4'd6) begin
            div_hold_s = CW'(DIV_CYCLES - 1);
        end else begin
            div_hold_s = '0;
        end
`else
        div_hold_s = '0;
`endif
    end

    // Grant is combinational and exists only in IDLE, never while in reset
    always_comb begin
        if (!rst && (state_r == IDLE) && found_s) begin
            req_ready = NREQ'(1'b1) << win_s;
        end else begin
            req_ready = '0;
        end
    end

    // Scheduler FSM: accept, issue to the ALU, and hold the response
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            ptr_r      <= '0;
            cnt_r      <= '0;
            alu_opcode <= 4'd0;
            alu_input1 <= '0;
            alu_input2 <= '0;
            alu_shift  <= 5'd0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_result <= '0;
            rsp_flags  <= 4'd0;
            rsp_err    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (found_s) begin
                        ptr_r  <= nxt_ptr_s;
                        rsp_id <= win_s;
                        if (sel_op_s <= 4'd8) begin
                            alu_opcode <= sel_op_s;
                            alu_input1 <= sel_in1_s;
                            alu_input2 <= sel_in2_s;
                            alu_shift  <= sel_sh_s;
                            cnt_r      <= div_hold_s;
                            state_r    <= ISSUE;
                        end else begin
                            // Unsupported opcode: ALU untouched, answer at once
                            rsp_result <= '0;
                            rsp_flags  <= 4'b0100;
                            rsp_err    <= 1'b1;
                            rsp_valid  <= 1'b1;
                            state_r    <= RESP;
                        end
                    end
                end
                ISSUE: begin
                    if (cnt_r == '0) begin
                        rsp_result <= alu_result;
                        rsp_flags  <= {alu_carry, alu_zero, alu_overflow, alu_sign};
                        rsp_err    <= 1'b0;
                        rsp_valid  <= 1'b1;
                        state_r    <= RESP;
                    end else begin
                        cnt_r <= cnt_r - CW'(1'b1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state_r   <= IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Bench for alu_rr_scheduler. A behavioural ALU is driven from the DUT's
// alu_* outputs. Per-requester op queues feed the request ports, and a
// scoreboard holds the expected responses in accept order.
module tb_alu_rr_scheduler;

    localparam int WIDTH      = 8;
    localparam int NREQ       = 2;
    localparam int DIV_CYCLES = 4;
    localparam int IDW        = 1;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [4*NREQ-1:0]      req_opcode;
    logic [WIDTH*NREQ-1:0]  req_input1;
    logic [WIDTH*NREQ-1:0]  req_input2;
    logic [5*NREQ-1:0]      req_shift;
    logic [3:0]             alu_opcode;
    logic [WIDTH-1:0]       alu_input1;
    logic [WIDTH-1:0]       alu_input2;
    logic [4:0]             alu_shift;
    logic [WIDTH-1:0]       alu_result;
    logic                   alu_carry, alu_zero, alu_overflow, alu_sign;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [IDW-1:0]         rsp_id;
    logic [WIDTH-1:0]       rsp_result;
    logic [3:0]             rsp_flags;
    logic                   rsp_err;

    typedef struct packed {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [4:0] sh;
    } op_t;

    typedef struct {
        logic [IDW-1:0] id;
        logic [7:0]     res;
        logic [3:0]     fl;
        logic           err;
        int             acc;
        int             lat;
        op_t            p;
    } exp_t;

    op_t  pq [NREQ][$];
    exp_t sb [$];
    int   gl [$];

    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc_n       = 0;
    int   ptr_m       = 0;
    int   last_hs     = -10;
    int   last_acc    = -10;
    logic prev_v      = 1'b0;
    logic prev_hs     = 1'b0;
    logic [IDW-1:0] p_id;
    logic [7:0]     p_res;
    logic [3:0]     p_fl;
    logic           p_err;
    op_t            last_alu = '0;
    logic [IDW-1:0] l_id;
    logic [7:0]     l_res;
    logic [3:0]     l_fl;
    logic           l_err;

    alu_rr_scheduler #(.WIDTH(WIDTH), .NREQ(NREQ), .DIV_CYCLES(DIV_CYCLES)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_opcode(req_opcode), .req_input1(req_input1),
        .req_input2(req_input2), .req_shift(req_shift),
        .alu_opcode(alu_opcode), .alu_input1(alu_input1),
        .alu_input2(alu_input2), .alu_shift(alu_shift),
        .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero),
        .alu_overflow(alu_overflow), .alu_sign(alu_sign),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    // Reference ALU: returns {result, carry, zero, overflow, sign}
    function automatic logic [11:0] alu_f(input logic [3:0] op, input logic [7:0] a,
                                          input logic [7:0] b, input logic [4:0] sh);
        logic [8:0] w;
        logic [7:0] r;
        logic       c;
        logic       v;
        w = 9'd0; r = 8'd0; c = 1'b0; v = 1'b0;
        case (op)
            4'd0: begin w = {1'b0, a} + {1'b0, b}; r = w[7:0]; c = w[8];
                        v = (a[7] == b[7]) && (r[7] != a[7]); end
            4'd1: begin w = {1'b0, a} - {1'b0, b}; r = w[7:0]; c = w[8];
                        v = (a[7] != b[7]) && (r[7] != a[7]); end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = a << sh;
            4'd6: r = (b == 8'd0) ? 8'hFF : a / b;
            4'd7: r = a >> sh;
            4'd8: r = ~a;
            default: r = 8'd0;
        endcase
        return {r, c, (r == 8'd0), v, r[7]};
    endfunction

    // Behavioural ALU seen by the DUT
    always_comb begin
        {alu_result, alu_carry, alu_zero, alu_overflow, alu_sign} =
            alu_f(alu_opcode, alu_input1, alu_input2, alu_shift);
    end

    function automatic int exp_lat(input logic [3:0] op);
        if (op > 4'd8) return 1;
`ifdef ALU_SCHED_DIV_MULTICYCLE_EN
        if (op == 4'd6) return DIV_CYCLES + 1;
`endif
        return 2;
    endfunction

    function automatic int rr_winner(input logic [NREQ-1:0] v, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic int pending();
        int n;
        n = sb.size();
        for (int i = 0; i < NREQ; i++) n += pq[i].size();
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive queue heads, check this cycle, record accepts, advance
    task automatic cyc();
        logic [NREQ-1:0] acc;
        logic            hs;
        logic            rst_s;
        int              w;
        exp_t            e;
        logic [11:0]     m;
        for (int i = 0; i < NREQ; i++) begin
            if (pq[i].size() > 0) begin
                req_valid[i]                 = 1'b1;
                req_opcode[4*i +: 4]         = pq[i][0].op;
                req_input1[WIDTH*i +: WIDTH] = pq[i][0].a;
                req_input2[WIDTH*i +: WIDTH] = pq[i][0].b;
                req_shift[5*i +: 5]          = pq[i][0].sh;
            end else begin
                req_valid[i] = 1'b0;
            end
        end
        #1;
        rst_s = rst;
        acc   = rst_s ? '0 : (req_valid & req_ready);
        hs    = rsp_valid & rsp_ready;
        if (rst_s) begin
            chk("ready_in_reset", 32'(req_ready), 32'd0);
        end else begin
            chk("ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
            if (sb.size() == 0) begin
                w = rr_winner(req_valid, ptr_m);
                chk("grant", 32'(req_ready), (w < 0) ? 32'd0 : (32'd1 << w));
            end else begin
                chk("ready_busy", 32'(req_ready), 32'd0);
            end
            if (prev_hs) begin
                chk("drop_after_hs", 32'(rsp_valid), 32'd0);
            end else if (prev_v) begin
                chk("hold_valid", 32'(rsp_valid), 32'd1);
                chk("hold_id", 32'(rsp_id), 32'(p_id));
                chk("hold_result", 32'(rsp_result), 32'(p_res));
                chk("hold_flags", 32'(rsp_flags), 32'(p_fl));
                chk("hold_err", 32'(rsp_err), 32'(p_err));
            end
            if (rsp_valid && !prev_v) begin
                if (sb.size() == 0) begin
                    chk("rsp_spurious", 32'd1, 32'd0);
                end else begin
                    chk("latency", 32'(cyc_n - sb[0].acc), 32'(sb[0].lat));
                    if (sb[0].err) begin
                        chk("alu_untouched", 32'({alu_opcode, alu_input1, alu_input2, alu_shift}),
                            32'(last_alu));
                    end
                end
            end
            if (sb.size() > 0 && !rsp_valid && !sb[0].err) begin
                chk("alu_issue", 32'({alu_opcode, alu_input1, alu_input2, alu_shift}), 32'(sb[0].p));
            end
            if (hs && sb.size() > 0) begin
                e = sb.pop_front();
                chk("rsp_id", 32'(rsp_id), 32'(e.id));
                chk("rsp_result", 32'(rsp_result), 32'(e.res));
                chk("rsp_flags", 32'(rsp_flags), 32'(e.fl));
                chk("rsp_err", 32'(rsp_err), 32'(e.err));
                l_id = rsp_id; l_res = rsp_result; l_fl = rsp_flags; l_err = rsp_err;
                last_hs = cyc_n;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (acc[i]) begin
                    e.id  = IDW'(i);
                    e.p   = pq[i][0];
                    e.acc = cyc_n;
                    e.lat = exp_lat(e.p.op);
                    e.err = (e.p.op > 4'd8);
                    if (e.err) begin
                        e.res = 8'd0;
                        e.fl  = 4'b0100;
                    end else begin
                        m        = alu_f(e.p.op, e.p.a, e.p.b, e.p.sh);
                        e.res    = m[11:4];
                        e.fl     = m[3:0];
                        last_alu = e.p;
                    end
                    sb.push_back(e);
                    gl.push_back(i);
                    ptr_m    = (i + 1) % NREQ;
                    last_acc = cyc_n;
                end
            end
        end
        prev_v  = rst_s ? 1'b0 : rsp_valid;
        prev_hs = rst_s ? 1'b0 : hs;
        p_id = rsp_id; p_res = rsp_result; p_fl = rsp_flags; p_err = rsp_err;
        @(posedge clk);
        #1;
        cyc_n++;
        if (rst_s) begin
            sb.delete();
            ptr_m    = 0;
            last_alu = '0;
        end
        for (int i = 0; i < NREQ; i++) begin
            if (acc[i]) void'(pq[i].pop_front());
        end
    endtask

    task automatic run_idle(input int bound);
        int n;
        n = 0;
        while (pending() != 0 && n < bound) begin
            cyc();
            n++;
        end
        chk("drain_in_time", 32'(n < bound), 32'd1);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_alu"}, 32'({req_ready, alu_opcode, alu_input1, alu_input2, alu_shift}), 32'd0);
        chk({tag, "_rsp"}, 32'({rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err}), 32'd0);
    endtask

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Directed sequence followed by a short random mix
    initial begin
        int n;
        op_t o;
        rst = 1'b1; rsp_ready = 1'b0; req_valid = '0;
        req_opcode = '0; req_input1 = '0; req_input2 = '0; req_shift = '0;
        cyc(); cyc(); cyc();
        rst = 1'b0;
        chk_zero_outputs("reset");

        // ADD 7F+01 from requester 0
        rsp_ready = 1'b1;
        pq[0].push_back('{4'd0, 8'h7F, 8'h01, 5'd0});
        run_idle(20);
        chk("add_result", 32'(l_res), 32'h80);
        chk("add_flags", 32'(l_fl), 32'b0011);
        chk("add_id", 32'(l_id), 32'd0);

        // Both requesters contend with four SUB 5-5 each, starting from reset
        rst = 1'b1; cyc(); rst = 1'b0;
        gl.delete();
        for (int k = 0; k < 4; k++) begin
            pq[0].push_back('{4'd1, 8'h05, 8'h05, 5'd0});
            pq[1].push_back('{4'd1, 8'h05, 8'h05, 5'd0});
        end
        run_idle(80);
        chk("grant_count", 32'(gl.size()), 32'd8);
        for (int k = 0; k < 8 && k < gl.size(); k++) chk("grant_order", 32'(gl[k]), 32'(k % 2));
        chk("sub_flags", 32'(l_fl), 32'b0100);

        // DIV 100/7
        pq[0].push_back('{4'd6, 8'd100, 8'd7, 5'd0});
        run_idle(30);
        chk("div_result", 32'(l_res), 32'd14);

        // Unsupported opcode from requester 1
        pq[1].push_back('{4'd12, 8'h55, 8'hAA, 5'd3});
        run_idle(20);
        chk("bad_err", 32'(l_err), 32'd1);
        chk("bad_result", 32'(l_res), 32'd0);
        chk("bad_flags", 32'(l_fl), 32'b0100);
        chk("bad_id", 32'(l_id), 32'd1);
        chk("bad_alu_kept", 32'({alu_opcode, alu_input1, alu_input2}), {12'd0, 4'd6, 8'd100, 8'd7});

        // Back-pressure: response held while requester 1 waits
        rsp_ready = 1'b0;
        pq[0].push_back('{4'd0, 8'd3, 8'd4, 5'd0});
        n = 0;
        while (!rsp_valid && n < 10) begin cyc(); n++; end
        chk("bp_rsp_seen", 32'(rsp_valid), 32'd1);
        pq[1].push_back('{4'd2, 8'hF0, 8'h3C, 5'd0});
        for (int k = 0; k < 5; k++) cyc();
        chk("bp_ready_low", 32'(req_ready), 32'd0);
        chk("bp_result", 32'(rsp_result), 32'd7);
        rsp_ready = 1'b1;
        cyc();
        cyc();
        chk("bp_accept_next", 32'(last_acc), 32'(last_hs + 1));
        run_idle(20);
        chk("bp_and_result", 32'(l_res), 32'h30);

        // Reset in the middle of a DIV issue; pointer must restart at 0
        pq[0].push_back('{4'd6, 8'd200, 8'd9, 5'd0});
        n = 0;
        while (sb.size() == 0 && n < 10) begin cyc(); n++; end
        chk("div_accepted", 32'(sb.size()), 32'd1);
        rst = 1'b1; cyc(); rst = 1'b0;
        chk_zero_outputs("midreset");
        gl.delete();
        pq[0].push_back('{4'd3, 8'h0F, 8'hF0, 5'd0});
        pq[1].push_back('{4'd4, 8'hFF, 8'h0F, 5'd0});
        cyc();
        chk("post_reset_grant", 32'(gl.size() > 0 ? gl[0] : -1), 32'd0);
        run_idle(30);

        // Random mix with random back-pressure
        for (int k = 0; k < 30; k++) begin
            o.op = 4'($urandom_range(0, 15));
            o.a  = 8'($urandom);
            o.b  = 8'($urandom);
            o.sh = 5'($urandom_range(0, 9));
            pq[$urandom_range(0, NREQ - 1)].push_back(o);
        end
        n = 0;
        while (pending() != 0 && n < 800) begin
            rsp_ready = 1'($urandom_range(0, 1));
            cyc();
            n++;
        end
        chk("random_drain", 32'(n < 800), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
